// File: rtl/simm_controller_pkg.sv
// Shared types and constants for the 72-pin FPM SIMM controller: FSM states,
// CPU address field positions and default DRAM timing.
package simm_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_ACK,
        ST_PRE,
        ST_REF_CAS,
        ST_REF_RAS
    } state_e;

    localparam logic [9:0] REFRESH_INTERVAL_DEF = 10'd380;
    localparam logic [1:0] RAS_TO_CAS_DEF       = 2'd1;
    localparam logic [1:0] CAS_WIDTH_DEF        = 2'd2;
    localparam logic [1:0] PRECHARGE_DEF        = 2'd2;
    localparam logic [1:0] REF_RAS_CLKS         = 2'd2;

    localparam int ADDR_MSB = 26;
    localparam int ADDR_LSB = 1;
    localparam int BANK_BIT = 26;
    localparam int ROW_MSB  = 25;
    localparam int ROW_LSB  = 14;
    localparam int COL_MSB  = 13;
    localparam int COL_LSB  = 2;

    function automatic logic in_access(input state_e s);
        return (s == ST_ROW) || (s == ST_COL) || (s == ST_ACK);
    endfunction

endpackage

// File: rtl/simm_if.sv
// CPU-side request/acknowledge and DRAM-side strobes/address of the SIMM slot.
interface simm_if;
    import simm_controller_pkg::*;

    logic                     cs;
    logic                     ds;
    logic                     rn_w;
    logic [ADDR_MSB:ADDR_LSB] addr;
    logic [3:0]               lanes;
    logic                     simm_ack;
    logic [3:0]               n_ras0;
    logic [3:0]               n_ras1;
    logic [3:0]               n_cas;
    logic                     n_simm_we;
    logic                     n_simm;
    logic [11:0]              simm_addr;

    modport master (
        output cs, ds, rn_w, addr, lanes,
        input  simm_ack, n_ras0, n_ras1, n_cas, n_simm_we, n_simm, simm_addr
    );

    modport slave (
        input  cs, ds, rn_w, addr, lanes,
        output simm_ack, n_ras0, n_ras1, n_cas, n_simm_we, n_simm, simm_addr
    );
endinterface

// File: rtl/simm_controller_refresh_timer.sv
// Free-running refresh interval counter; raises pending on each wrap until the
// controller reports the refresh as serviced.
module simm_controller_refresh_timer #(
    parameter logic [9:0] INTERVAL = 10'd380
) (
    input  logic clock,
    input  logic reset,
    input  logic serviced,
    output logic pending
);
    logic [9:0] count_q, count_d;
    logic       pending_q, pending_d;
    logic       wrap;

    // A wrap coinciding with a service keeps pending set so the new interval is not lost.
    always_comb begin
        wrap      = (count_q == INTERVAL - 10'd1);
        count_d   = wrap ? 10'd0 : count_q + 10'd1;
        pending_d = pending_q;
        if (wrap) begin
            pending_d = 1'b1;
        end else if (serviced) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= 10'd0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

// File: rtl/simm_controller.sv
// FPM DRAM controller: sequences RAS/CAS/WE and the row/column mux for CPU
// long-word accesses and interleaves CAS-before-RAS refresh.
module simm_controller
    import simm_controller_pkg::*;
#(
    parameter logic [9:0] REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
    parameter logic [1:0] RAS_TO_CAS       = RAS_TO_CAS_DEF,
    parameter logic [1:0] CAS_WIDTH        = CAS_WIDTH_DEF,
    parameter logic [1:0] PRECHARGE        = PRECHARGE_DEF
) (
    input  logic    clock,
    input  logic    reset,
    simm_if.slave   bus
);
    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        bank_q, bank_d;
    logic [11:0] row_q, row_d;
    logic [11:0] col_q, col_d;
    logic [3:0]  lanes_q, lanes_d;
    logic        rn_w_q, rn_w_d;
    logic        ack_q, ack_d;
    logic [3:0]  n_ras0_q, n_ras0_d;
    logic [3:0]  n_ras1_q, n_ras1_d;
    logic [3:0]  n_cas_q, n_cas_d;
    logic        n_we_q, n_we_d;
    logic        n_simm_q, n_simm_d;
    logic [11:0] simm_addr_q, simm_addr_d;
    logic        pending;
    logic        serviced;
    logic        take_idle;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = bus.addr[ADDR_LSB];

    simm_controller_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clock    (clock),
        .reset    (reset),
        .serviced (serviced),
        .pending  (pending)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        lanes_d     = lanes_q;
        rn_w_d      = rn_w_q;
        simm_addr_d = simm_addr_q;
        serviced    = 1'b0;
        take_idle   = 1'b0;

        case (state_q)
            ST_IDLE: take_idle = 1'b1;
            ST_ROW: begin
                if (!bus.cs) begin
                    state_d = ST_PRE;
                    cnt_d   = PRECHARGE - 2'd1;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (rn_w_q || bus.ds) begin
                    state_d     = ST_COL;
                    cnt_d       = CAS_WIDTH - 2'd1;
                    simm_addr_d = col_q;
                end
            end
            ST_COL: begin
                if (!bus.cs) begin
                    state_d = ST_PRE;
                    cnt_d   = PRECHARGE - 2'd1;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!bus.cs) begin
                    state_d = ST_PRE;
                    cnt_d   = PRECHARGE - 2'd1;
                end
            end
            ST_PRE: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    take_idle = 1'b1;
                end
            end
            ST_REF_CAS: begin
                state_d = ST_REF_RAS;
                cnt_d   = REF_RAS_CLKS - 2'd1;
            end
            ST_REF_RAS: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d = ST_PRE;
                    cnt_d   = PRECHARGE - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // End of precharge makes the idle decision on the same edge, so a waiting
        // access or refresh loses no extra clock.
        if (take_idle) begin
            state_d = ST_IDLE;
            if (pending) begin
                state_d  = ST_REF_CAS;
                serviced = 1'b1;
            end else if (bus.cs) begin
                state_d     = ST_ROW;
                cnt_d       = RAS_TO_CAS - 2'd1;
                bank_d      = bus.addr[BANK_BIT];
                row_d       = bus.addr[ROW_MSB:ROW_LSB];
                col_d       = bus.addr[COL_MSB:COL_LSB];
                lanes_d     = bus.lanes;
                rn_w_d      = bus.rn_w;
                simm_addr_d = bus.addr[ROW_MSB:ROW_LSB];
            end
        end

        ack_d    = 1'b0;
        n_ras0_d = 4'hF;
        n_ras1_d = 4'hF;
        n_cas_d  = 4'hF;
        n_we_d   = 1'b1;
        case (state_d)
            ST_ROW: begin
                if (bank_d) n_ras1_d = 4'h0;
                else        n_ras0_d = 4'h0;
            end
            ST_COL, ST_ACK: begin
                if (bank_d) n_ras1_d = 4'h0;
                else        n_ras0_d = 4'h0;
                n_cas_d = ~lanes_d;
                n_we_d  = rn_w_d;
                ack_d   = (state_d == ST_ACK);
            end
            ST_REF_CAS: n_cas_d = 4'h0;
            ST_REF_RAS: begin
                n_cas_d  = 4'h0;
                n_ras0_d = 4'h0;
                n_ras1_d = 4'h0;
            end
            default: ;
        endcase
        n_simm_d = ~(bus.ds && in_access(state_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            bank_q      <= 1'b0;
            row_q       <= 12'd0;
            col_q       <= 12'd0;
            lanes_q     <= 4'd0;
            rn_w_q      <= 1'b1;
            ack_q       <= 1'b0;
            n_ras0_q    <= 4'hF;
            n_ras1_q    <= 4'hF;
            n_cas_q     <= 4'hF;
            n_we_q      <= 1'b1;
            n_simm_q    <= 1'b1;
            simm_addr_q <= 12'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            lanes_q     <= lanes_d;
            rn_w_q      <= rn_w_d;
            ack_q       <= ack_d;
            n_ras0_q    <= n_ras0_d;
            n_ras1_q    <= n_ras1_d;
            n_cas_q     <= n_cas_d;
            n_we_q      <= n_we_d;
            n_simm_q    <= n_simm_d;
            simm_addr_q <= simm_addr_d;
        end
    end

    assign bus.simm_ack  = ack_q;
    assign bus.n_ras0    = n_ras0_q;
    assign bus.n_ras1    = n_ras1_q;
    assign bus.n_cas     = n_cas_q;
    assign bus.n_simm_we = n_we_q;
    assign bus.n_simm    = n_simm_q;
    assign bus.simm_addr = simm_addr_q;
endmodule

// File: tb/tb_simm_controller.sv
// Bench for simm_controller: timeline reference model checked every cycle,
// directed timing cases with literal expectations, then randomized CPU traffic.
module tb_simm_controller;
    localparam logic [9:0] INTERVAL = 10'd16;
    localparam int RTC = 1;
    localparam int CW  = 2;
    localparam int PRE = 2;
    localparam int INF = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst;
    simm_if bus ();

    simm_controller #(
        .REFRESH_INTERVAL (INTERVAL),
        .RAS_TO_CAS       (2'(RTC)),
        .CAS_WIDTH        (2'(CW)),
        .PRECHARGE        (2'(PRE))
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: an access or refresh is a timeline of edge stamps.
    int          n = 0;
    bit          model_valid = 0;
    bit          m_acc;
    int          t_start, t_col, t_ack, free_at, ref_start;
    bit          ref_valid;
    bit          m_bank, m_rnw;
    logic [11:0] m_row, m_col, m_addr;
    logic [3:0]  m_lanes;
    int          m_timer;
    bit          m_pend, m_pend_old, m_wrap, m_serv;
    logic        e_ack, e_we, e_nsimm;
    logic [3:0]  e_ras0, e_ras1, e_cas;
    logic [26:0] m_full;

    always @(posedge clk) begin
        n++;
        if (rst) begin
            model_valid = 1;
            m_acc = 0; ref_valid = 0; free_at = n + 1;
            m_timer = 0; m_pend = 0; m_addr = 12'd0;
        end else if (model_valid) begin
            m_pend_old = m_pend;
            m_wrap  = (m_timer == int'(INTERVAL) - 1);
            m_timer = m_wrap ? 0 : m_timer + 1;
            m_serv  = 0;
            if (m_acc) begin
                if (!bus.cs) begin
                    m_acc = 0;
                    free_at = n + PRE;
                end else if (t_col == INF && n >= t_start + RTC && (m_rnw || bus.ds)) begin
                    t_col = n; t_ack = n + CW; m_addr = m_col;
                end
            end else if (n >= free_at) begin
                if (m_pend_old) begin
                    ref_valid = 1; ref_start = n; free_at = n + 3 + PRE; m_serv = 1;
                end else if (bus.cs) begin
                    m_full = {bus.addr, 1'b0};
                    m_acc = 1; t_start = n; t_col = INF; t_ack = INF;
                    m_bank = m_full[26]; m_row = m_full[25:14]; m_col = m_full[13:2];
                    m_lanes = bus.lanes; m_rnw = bus.rn_w; m_addr = m_row;
                end
            end
            if (m_wrap) m_pend = 1;
            else if (m_serv) m_pend = 0;
        end
        e_ack = 0; e_we = 1; e_ras0 = 4'hF; e_ras1 = 4'hF; e_cas = 4'hF;
        if (m_acc) begin
            if (m_bank) e_ras1 = 4'h0; else e_ras0 = 4'h0;
            if (n >= t_col) begin
                e_cas = ~m_lanes; e_we = m_rnw;
                if (n >= t_ack) e_ack = 1;
            end
        end else if (ref_valid && n - ref_start <= 2) begin
            e_cas = 4'h0;
            if (n - ref_start >= 1) begin e_ras0 = 4'h0; e_ras1 = 4'h0; end
        end
        e_nsimm = !(m_acc && bus.ds && !rst);
        #1;
        if (model_valid) begin
            chk("m_ack",  bus.simm_ack, e_ack);
            chk("m_ras0", bus.n_ras0, e_ras0);
            chk("m_ras1", bus.n_ras1, e_ras1);
            chk("m_cas",  bus.n_cas, e_cas);
            chk("m_we",   bus.n_simm_we, e_we);
            chk("m_simm", bus.n_simm, e_nsimm);
            chk("m_addr", bus.simm_addr, m_addr);
        end
    end

    int rel;
    logic [26:0] a;

    task automatic step_to(input int k);
        while (rel < k) begin
            @(negedge clk);
            rel++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; bus.cs = 0; bus.ds = 0;
        @(negedge clk);
        rst = 0; rel = 0;
    endtask

    task automatic start(input logic [26:0] ad, input logic rw, input logic [3:0] ln, input logic d);
        a = ad;
        bus.addr = a[26:1]; bus.rn_w = rw; bus.lanes = ln; bus.ds = d; bus.cs = 1;
    endtask

    int cs_cycles, acks_seen;

    initial begin
        rst = 1; bus.cs = 0; bus.ds = 0; bus.rn_w = 1; bus.addr = '0; bus.lanes = 4'hF;
        rel = 0;
        do_reset();
        chk("rst_ras0", bus.n_ras0, 4'hF);
        chk("rst_cas", bus.n_cas, 4'hF);
        chk("rst_ack", bus.simm_ack, 1'b0);
        chk("rst_addr", bus.simm_addr, 12'h000);

        // read with best-case timing, then idle refresh, then refresh/cs collision
        start(27'h0012344, 1'b1, 4'hF, 1'b1);
        step_to(1); chk("t1_ras0", bus.n_ras0, 4'h0); chk("t1_row", bus.simm_addr, 12'h004);
        step_to(2); chk("t1_col", bus.simm_addr, 12'h8D1); chk("t1_cas", bus.n_cas, 4'h0);
        step_to(3); chk("t1_ack3", bus.simm_ack, 1'b0);
        step_to(4); chk("t1_ack4", bus.simm_ack, 1'b1); chk("t1_we", bus.n_simm_we, 1'b1);
        bus.cs = 0; bus.ds = 0;
        step_to(16); chk("t3_nopend", bus.n_cas, 4'hF);
        step_to(17); chk("t3_cas", bus.n_cas, 4'h0); chk("t3_ras_hi", bus.n_ras0, 4'hF);
        step_to(18); chk("t3_ras0", bus.n_ras0, 4'h0); chk("t3_ras1", bus.n_ras1, 4'h0);
        step_to(20); chk("t3_pre", bus.n_cas, 4'hF);
        step_to(32);
        start(27'h0000100, 1'b1, 4'hF, 1'b1);
        step_to(33); chk("t4_refcas", bus.n_cas, 4'h0); chk("t4_noras", bus.n_ras0, 4'hF);
        for (int k = 34; k <= 41; k++) begin
            step_to(k);
            chk("t4_ack", bus.simm_ack, (k == 41));
        end
        bus.cs = 0; bus.ds = 0;

        // byte write to bank 1 with ds arriving three clocks late
        do_reset();
        start(27'h4ABCDE0, 1'b0, 4'b0100, 1'b0);
        step_to(1); chk("t2_ras1", bus.n_ras1, 4'h0); chk("t2_ras0", bus.n_ras0, 4'hF);
        chk("t2_row", bus.simm_addr, 12'h2AF);
        step_to(2); chk("t2_wait2", bus.n_cas, 4'hF);
        step_to(3); chk("t2_wait3", bus.n_cas, 4'hF);
        bus.ds = 1;
        step_to(4); chk("t2_cas", bus.n_cas, 4'b1011); chk("t2_we", bus.n_simm_we, 1'b0);
        step_to(6); chk("t2_ack", bus.simm_ack, 1'b1);
        bus.cs = 0; bus.ds = 0;

        // abort in COL, then a cs that must wait out the two precharge clocks
        do_reset();
        start(27'h0000040, 1'b1, 4'hF, 1'b1);
        step_to(2); chk("t5_cas", bus.n_cas, 4'h0);
        bus.cs = 0;
        step_to(3); chk("t5_ras", bus.n_ras0, 4'hF); chk("t5_cas_off", bus.n_cas, 4'hF);
        chk("t5_ack", bus.simm_ack, 1'b0);
        bus.cs = 1;
        step_to(4); chk("t5_pre2", bus.n_ras0, 4'hF);
        step_to(5); chk("t5_reopen", bus.n_ras0, 4'h0);
        step_to(8); chk("t5_ack2", bus.simm_ack, 1'b1);
        bus.cs = 0; bus.ds = 0;

        // reset in COL, refresh timer restarts
        do_reset();
        start(27'h0000080, 1'b1, 4'hF, 1'b1);
        step_to(2); chk("t6_cas", bus.n_cas, 4'h0);
        rst = 1;
        step_to(3);
        chk("t6_cas_off", bus.n_cas, 4'hF); chk("t6_ras0", bus.n_ras0, 4'hF);
        chk("t6_ras1", bus.n_ras1, 4'hF); chk("t6_ack", bus.simm_ack, 1'b0);
        rst = 0; bus.cs = 0; bus.ds = 0; rel = 0;
        step_to(16); chk("t6_nopend", bus.n_cas, 4'hF);
        step_to(17); chk("t6_refresh", bus.n_cas, 4'h0);

        // randomized CPU traffic
        do_reset();
        cs_cycles = 0; acks_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst) rst = 0;
            else if ($urandom_range(0, 499) == 0) rst = 1;
            if (!bus.cs) begin
                cs_cycles = 0;
                if ($urandom_range(0, 2) == 0) begin
                    bus.rn_w  = 1'($urandom);
                    bus.addr  = 26'($urandom);
                    bus.lanes = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
                    bus.ds    = bus.rn_w;
                    bus.cs    = 1;
                end
            end else begin
                cs_cycles++;
                if (!bus.ds && $urandom_range(0, 2) == 0) bus.ds = 1;
                if (bus.simm_ack) begin
                    acks_seen++;
                    bus.cs = 0; bus.ds = 0;
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.cs = 0; bus.ds = 0;
                end else if (cs_cycles > 50) begin
                    n_checks++; n_fail++;
                    $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack within 50", cs_cycles);
                    bus.cs = 0; bus.ds = 0;
                end
            end
        end
        chk("rand_acks", 32'(acks_seen > 20), 32'd1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1ms");
        $fatal(1);
    end
endmodule
